// File: rtl/shift_add_multiplier.sv
// Sequential signed multiplier, radix-2 Booth recoding, one add/sub-and-shift
// step per clock. Product is available B_bits+1 edges after start is sampled.
//
// Ports:
//   CLK       in   system clock, rising edge
//   RESET_N   in   asynchronous active-low reset
//   start     in   level request; must drop before the next request
//   A         in   signed multiplicand, A_bits wide
//   B         in   signed multiplier, B_bits wide (sets iteration count)
//   S         out  signed product, A_bits+B_bits wide, registered
//   fin_mult  out  completion flag, registered
//
// Optional build macro: MULT_ZERO_SKIP_EN -- when defined, a zero operand
// bypasses the Booth iterations and completes at edge 1 with S = 0.
module shift_add_multiplier #(
  parameter int unsigned A_bits = 8,
  parameter int unsigned B_bits = 8
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       start,
  input  logic [A_bits-1:0]          A,
  input  logic [B_bits-1:0]          B,
  output logic [A_bits+B_bits-1:0]   S,
  output logic                       fin_mult
);

  localparam int unsigned ACC_W  = A_bits + 1;
  localparam int unsigned PROD_W = A_bits + B_bits;
  localparam int unsigned CNT_W  = $clog2(B_bits + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [ACC_W-1:0]    m, m_nxt;
  logic [ACC_W-1:0]    acc, acc_nxt;
  logic [B_bits-1:0]   q, q_nxt;
  logic                q_1, q_1_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [PROD_W-1:0]   s_nxt;
  logic                fin_nxt;
  logic [ACC_W-1:0]    booth_sum;
  logic                zero_op;

`ifdef MULT_ZERO_SKIP_EN
  assign zero_op = (A == '0) || (B == '0);
`else
  assign zero_op = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = zero_op ? DONE : CALC;
      // cnt reaches zero on this edge: the last Booth step is being taken
      CALC: if (cnt == CNT_W'(1)) state_nxt = DONE;
      // First DONE edge publishes the product; leave only once it is visible
      DONE: if (fin_mult && !start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    m_nxt     = m;
    acc_nxt   = acc;
    q_nxt     = q;
    q_1_nxt   = q_1;
    cnt_nxt   = cnt;
    s_nxt     = S;
    fin_nxt   = fin_mult;
    booth_sum = acc;
    case (state)
      IDLE: begin
        fin_nxt = 1'b0;
        if (start) begin
          m_nxt   = {A[A_bits-1], A};
          acc_nxt = '0;
          q_1_nxt = 1'b0;
          if (zero_op) begin
            // acc/Q left at zero so the DONE edge writes S = 0
            q_nxt   = '0;
            cnt_nxt = '0;
          end else begin
            q_nxt   = B;
            cnt_nxt = CNT_W'(B_bits);
          end
        end
      end
      CALC: begin
        case ({q[0], q_1})
          2'b10:   booth_sum = acc - m;
          2'b01:   booth_sum = acc + m;
          default: booth_sum = acc;
        endcase
        // Arithmetic right shift of {acc, Q, q_1}
        acc_nxt = {booth_sum[ACC_W-1], booth_sum[ACC_W-1:1]};
        q_nxt   = {booth_sum[0], q[B_bits-1:1]};
        q_1_nxt = q[0];
        cnt_nxt = cnt - CNT_W'(1);
      end
      DONE: begin
        if (!fin_mult) begin
          // Guard bit is redundant in the final product; drop the top bit
          s_nxt   = PROD_W'({acc, q});
          fin_nxt = 1'b1;
        end else if (!start) begin
          fin_nxt = 1'b0;
        end
      end
      default: fin_nxt = 1'b0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m        <= '0;
      acc      <= '0;
      q        <= '0;
      q_1      <= 1'b0;
      cnt      <= '0;
      S        <= '0;
      fin_mult <= 1'b0;
    end else begin
      m        <= m_nxt;
      acc      <= acc_nxt;
      q        <= q_nxt;
      q_1      <= q_1_nxt;
      cnt      <= cnt_nxt;
      S        <= s_nxt;
      fin_mult <= fin_nxt;
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier at default widths (8x8).
// Reference is plain signed integer multiplication plus the expected latency.
module tb_shift_add_multiplier;

  logic        CLK;
  logic        RESET_N;
  logic        start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] S;
  logic        fin_mult;

  int checks;
  int failures;

  shift_add_multiplier #(.A_bits(8), .B_bits(8)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .start    (start),
    .A        (A),
    .B        (B),
    .S        (S),
    .fin_mult (fin_mult)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_latency(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_ZERO_SKIP_EN
    if (a == 8'd0 || b == 8'd0) return 1;
`endif
    return 9;
  endfunction

  // One full operation: start, wait for completion, optional hold, release.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input bit change_a, input bit hold);
    int          lat;
    int          prod;
    logic [15:0] exp_s;
    prod  = $signed(a) * $signed(b);
    exp_s = 16'(prod);
    A = a;
    B = b;
    start = 1'b1;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (change_a && c == 2) A = 8'd3;
      if (fin_mult) begin
        lat = c;
        break;
      end
    end
    chk($sformatf("latency %0d*%0d", $signed(a), $signed(b)), 32'(lat), 32'(exp_latency(a, b)));
    chk($sformatf("product %0d*%0d", $signed(a), $signed(b)), 32'(S), 32'(exp_s));
    if (hold) begin
      repeat (3) @(negedge CLK);
      chk("hold fin_mult", 32'(fin_mult), 32'd1);
      chk("hold product", 32'(S), 32'(exp_s));
    end
    start = 1'b0;
    @(negedge CLK);
    chk("release fin_mult", 32'(fin_mult), 32'd0);
    chk("release holds S", 32'(S), 32'(exp_s));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RESET_N  = 1'b0;
    start    = 1'b0;
    A        = 8'd0;
    B        = 8'd0;
    repeat (2) @(negedge CLK);
    chk("reset S", 32'(S), 32'd0);
    chk("reset fin_mult", 32'(fin_mult), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Directed cases
    run_op(8'd45, 8'd96, 1'b0, 1'b0);
    run_op(8'(-45), 8'd96, 1'b0, 1'b0);
    run_op(8'd45, 8'(-96), 1'b0, 1'b0);
    run_op(8'(-45), 8'(-96), 1'b0, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 1'b0);
    run_op(8'h80, 8'd127, 1'b0, 1'b0);
    run_op(8'd127, 8'd127, 1'b0, 1'b0);
    run_op(8'd45, 8'd96, 1'b1, 1'b1);
    run_op(8'd0, 8'd77, 1'b0, 1'b0);
    run_op(8'd77, 8'd0, 1'b0, 1'b0);

    // Reset mid-calculation aborts with no partial result
    A = 8'd45;
    B = 8'd96;
    start = 1'b1;
    repeat (5) @(negedge CLK);
    chk("mid-calc fin_mult low", 32'(fin_mult), 32'd0);
    RESET_N = 1'b0;
    #1;
    chk("async reset S", 32'(S), 32'd0);
    chk("async reset fin_mult", 32'(fin_mult), 32'd0);
    start = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    run_op(8'(-7), 8'd99, 1'b0, 1'b0);

    // Randomized operands against the integer model
    for (int i = 0; i < 30; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'b0, ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
